// File: rtl/fact_scheduler.sv
// fact_scheduler: round-robin arbiter sharing one factorial engine among NREQ
// requesters. One operand is issued at a time. The result and error flag are
// routed back to the requester that owns the operation.
//
// Optional feature: define FACT_SCHED_TIMEOUT_EN to force an error completion
// after TIMEOUT BUSY cycles without an engine response.
//
// Ports:
//   clk, rst        clock (rising edge), asynchronous active-high reset
//   req[NREQ]       level request per requester
//   req_in[4*NREQ]  operands, requester i on bits [4i+3:4i]
//   ack[NREQ]       one-cycle grant pulse, operand latched
//   rsp_valid[NREQ] one-cycle completion pulse for the owning requester
//   rsp_result      32-bit result of the last completion (held)
//   rsp_error       engine error or timeout of the last completion (held)
//   rsp_timeout     last completion was forced by timeout (held)
//   busy            high whenever the FSM is not idle
//   eng_go, eng_in  engine start pulse and operand (operand held)
//   eng_done, eng_error, eng_result  engine status and result
module fact_scheduler #(
    parameter int unsigned NREQ    = 4,
    parameter int unsigned TIMEOUT = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req,
    input  logic [4*NREQ-1:0] req_in,
    output logic [NREQ-1:0]   ack,
    output logic [NREQ-1:0]   rsp_valid,
    output logic [31:0]       rsp_result,
    output logic              rsp_error,
    output logic              rsp_timeout,
    output logic              busy,
    output logic              eng_go,
    output logic [3:0]        eng_in,
    input  logic              eng_done,
    input  logic              eng_error,
    input  logic [31:0]       eng_result
);
    localparam int unsigned IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    if (NREQ < 2 || NREQ > 8 || TIMEOUT < 2 || TIMEOUT > 65535) begin : g_param_check
        $error("fact_scheduler: NREQ or TIMEOUT out of range");
    end

    typedef enum logic [1:0] {IDLE, ISSUE, BUSY, RESP} state_t;

    state_t          state, state_n;
    logic [IW-1:0]   ptr, ptr_n;
    logic [IW-1:0]   owner, owner_n;
    logic            blank, blank_n;
    logic [NREQ-1:0] ack_n, rsp_valid_n;
    logic [31:0]     rsp_result_n;
    logic            rsp_error_n;
    logic            busy_n;
    logic            eng_go_n;
    logic [3:0]      eng_in_n;

    logic [3:0]      ops [NREQ];
    logic            grant_hit;
    logic [IW-1:0]   grant_idx;
    logic [IW-1:0]   cand;

    for (genvar g = 0; g < NREQ; g++) begin : g_ops
        assign ops[g] = req_in[4*g +: 4];
    end

    // Scan starts one past the last grant so the previous owner gets lowest priority.
    always_comb begin
        grant_hit = 1'b0;
        grant_idx = '0;
        cand      = '0;
        for (int unsigned k = 1; k <= NREQ; k++) begin
            cand = IW'((32'(ptr) + k) % NREQ);
            if (!grant_hit && req[cand]) begin
                grant_hit = 1'b1;
                grant_idx = cand;
            end
        end
    end

`ifdef FACT_SCHED_TIMEOUT_EN
    localparam logic [15:0] TIMEOUT_LIM = 16'(TIMEOUT);
    logic [15:0] timer, timer_n;
    logic        rsp_timeout_n;
`else
    assign rsp_timeout = 1'b0;
`endif

    always_comb begin
        state_n      = state;
        ptr_n        = ptr;
        owner_n      = owner;
        blank_n      = blank;
        ack_n        = '0;
        rsp_valid_n  = '0;
        rsp_result_n = rsp_result;
        rsp_error_n  = rsp_error;
        eng_go_n     = 1'b0;
        eng_in_n     = eng_in;
`ifdef FACT_SCHED_TIMEOUT_EN
        timer_n       = timer;
        rsp_timeout_n = rsp_timeout;
`endif
        unique case (state)
            IDLE: begin
                if (grant_hit) begin
                    state_n          = ISSUE;
                    owner_n          = grant_idx;
                    ptr_n            = grant_idx;
                    ack_n[grant_idx] = 1'b1;
                    // go/in are registered here so they are visible throughout ISSUE.
                    eng_go_n         = 1'b1;
                    eng_in_n         = ops[grant_idx];
                end
            end
            ISSUE: begin
                state_n = BUSY;
                blank_n = 1'b1;
`ifdef FACT_SCHED_TIMEOUT_EN
                timer_n = '0;
`endif
            end
            BUSY: begin
                // First BUSY cycle ignores status possibly left over from the previous run.
                blank_n = 1'b0;
`ifdef FACT_SCHED_TIMEOUT_EN
                timer_n = timer + 16'd1;
`endif
                if (!blank && (eng_done || eng_error)) begin
                    state_n            = RESP;
                    rsp_valid_n[owner] = 1'b1;
                    rsp_result_n       = eng_result;
                    rsp_error_n        = eng_error;
`ifdef FACT_SCHED_TIMEOUT_EN
                    rsp_timeout_n      = 1'b0;
                end else if (timer_n == TIMEOUT_LIM) begin
                    state_n            = RESP;
                    rsp_valid_n[owner] = 1'b1;
                    rsp_result_n       = '0;
                    rsp_error_n        = 1'b1;
                    rsp_timeout_n      = 1'b1;
`endif
                end
            end
            RESP:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
        busy_n = (state_n != IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            ptr        <= IW'(NREQ - 1);
            owner      <= '0;
            blank      <= 1'b0;
            ack        <= '0;
            rsp_valid  <= '0;
            rsp_result <= '0;
            rsp_error  <= 1'b0;
            busy       <= 1'b0;
            eng_go     <= 1'b0;
            eng_in     <= '0;
        end else begin
            state      <= state_n;
            ptr        <= ptr_n;
            owner      <= owner_n;
            blank      <= blank_n;
            ack        <= ack_n;
            rsp_valid  <= rsp_valid_n;
            rsp_result <= rsp_result_n;
            rsp_error  <= rsp_error_n;
            busy       <= busy_n;
            eng_go     <= eng_go_n;
            eng_in     <= eng_in_n;
        end
    end

`ifdef FACT_SCHED_TIMEOUT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            timer       <= '0;
            rsp_timeout <= 1'b0;
        end else begin
            timer       <= timer_n;
            rsp_timeout <= rsp_timeout_n;
        end
    end
`endif

endmodule

// File: tb/tb_fact_scheduler.sv
// Directed testbench for fact_scheduler (NREQ=4, TIMEOUT=8). The engine is
// driven directly by the stimulus with hand-computed results.
module tb_fact_scheduler;
    logic        clk;
    logic        rst;
    logic [3:0]  req;
    logic [15:0] req_in;
    logic [3:0]  ack;
    logic [3:0]  rsp_valid;
    logic [31:0] rsp_result;
    logic        rsp_error;
    logic        rsp_timeout;
    logic        busy;
    logic        eng_go;
    logic [3:0]  eng_in;
    logic        eng_done;
    logic        eng_error;
    logic [31:0] eng_result;

    int nvec;
    int nerr;
    int n;
    int last_wait;

    fact_scheduler #(.NREQ(4), .TIMEOUT(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .req        (req),
        .req_in     (req_in),
        .ack        (ack),
        .rsp_valid  (rsp_valid),
        .rsp_result (rsp_result),
        .rsp_error  (rsp_error),
        .rsp_timeout(rsp_timeout),
        .busy       (busy),
        .eng_go     (eng_go),
        .eng_in     (eng_in),
        .eng_done   (eng_done),
        .eng_error  (eng_error),
        .eng_result (eng_result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %0d (0x%0h) expected %0d (0x%0h)", tag, obs, obs, exp, exp);
        end
    endtask

    // One full operation: grant of `who`, engine completes after `lat` post-blanking cycles.
    task automatic op(input int who, input logic [3:0] opnd, input logic [31:0] res,
                      input logic dn, input logic er, input int lat,
                      input logic stale, input logic [3:0] drop);
        logic [3:0] oh;
        int w;
        oh = 4'b0001 << who;
        if (stale) begin
            eng_done   = 1'b1;
            eng_result = 32'd999;
        end
        w = 0;
        do begin
            step();
            w++;
        end while (eng_go !== 1'b1 && w < 20);
        last_wait = w;
        check("grant_go", eng_go, 1);
        check("grant_ack", ack, oh);
        check("grant_in", eng_in, opnd);
        check("grant_busy", busy, 1);
        req = req & ~drop;
        step();
        check("go_pulse", eng_go, 0);
        check("ack_pulse", ack, 0);
        for (int i = 0; i < lat; i++) begin
            step();
            check("no_early_rsp", rsp_valid, 0);
            if (i == 0) begin
                eng_done   = 1'b0;
                eng_result = '0;
            end
        end
        eng_done   = dn;
        eng_error  = er;
        eng_result = res;
        step();
        check("rsp_valid", rsp_valid, oh);
        check("rsp_result", rsp_result, res);
        check("rsp_error", rsp_error, er);
        check("rsp_timeout", rsp_timeout, 0);
        eng_done   = 1'b0;
        eng_error  = 1'b0;
        eng_result = 32'hFFFF_FFFF;
        step();
        check("rsp_pulse", rsp_valid, 0);
        check("idle_busy", busy, 0);
        check("result_hold", rsp_result, res);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    initial begin
        nvec       = 0;
        nerr       = 0;
        rst        = 1'b1;
        req        = '0;
        req_in     = '0;
        eng_done   = 1'b0;
        eng_error  = 1'b0;
        eng_result = '0;

        // Reset values
        step();
        step();
        check("rst_ack", ack, 0);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_go", eng_go, 0);
        check("rst_in", eng_in, 0);
        check("rst_result", rsp_result, 0);
        rst = 1'b0;

        // Single request: requester 2, 5! = 120
        req    = 4'b0100;
        req_in = 16'h0500;
        op(2, 4'd5, 32'd120, 1'b1, 1'b0, 4, 1'b0, 4'b0100);
        check("single_latency", last_wait, 1);

        // Round-robin from a fresh reset: 0,1,2,3,0
        do_reset();
        req    = 4'b1111;
        req_in = 16'h4321;
        op(0, 4'd1, 32'd1,  1'b1, 1'b0, 1, 1'b0, 4'b0000);
        op(1, 4'd2, 32'd2,  1'b1, 1'b0, 2, 1'b0, 4'b0000);
        op(2, 4'd3, 32'd6,  1'b1, 1'b0, 2, 1'b0, 4'b0000);
        op(3, 4'd4, 32'd24, 1'b1, 1'b0, 2, 1'b0, 4'b0000);
        op(0, 4'd1, 32'd1,  1'b1, 1'b0, 2, 1'b0, 4'b1111);

        // Error forwarding: operand 13 on requester 1
        req    = 4'b0010;
        req_in = 16'h00D0;
        op(1, 4'd13, 32'd0, 1'b0, 1'b1, 3, 1'b0, 4'b0010);

        // Done and Error together report an error
        req    = 4'b0001;
        req_in = 16'h000F;
        op(0, 4'd15, 32'h1234_5678, 1'b1, 1'b1, 2, 1'b0, 4'b0001);

        // Stale Done held through the blanking cycle
        req    = 4'b1000;
        req_in = 16'h3000;
        op(3, 4'd3, 32'd6, 1'b1, 1'b0, 3, 1'b1, 4'b1000);

`ifdef FACT_SCHED_TIMEOUT_EN
        // Engine never completes: forced completion on the 8th BUSY edge
        req    = 4'b0010;
        req_in = 16'h0090;
        n = 0;
        do begin
            step();
            n++;
        end while (eng_go !== 1'b1 && n < 20);
        check("to_go", eng_go, 1);
        check("to_ack", ack, 4'b0010);
        req = '0;
        step();
        for (int i = 0; i < 7; i++) begin
            step();
            check("to_wait", rsp_valid, 0);
        end
        step();
        check("to_valid", rsp_valid, 4'b0010);
        check("to_error", rsp_error, 1);
        check("to_flag", rsp_timeout, 1);
        check("to_result", rsp_result, 0);
        step();
        check("to_idle", busy, 0);
        check("to_hold", rsp_timeout, 1);
`endif

        // Reset in the middle of BUSY
        req    = 4'b0100;
        req_in = 16'h0700;
        n = 0;
        do begin
            step();
            n++;
        end while (eng_go !== 1'b1 && n < 20);
        check("mid_go", eng_go, 1);
        check("mid_ack", ack, 4'b0100);
        req = '0;
        step();
        step();
        check("mid_busy", busy, 1);
        rst = 1'b1;
        #1;
        check("mid_rst_busy", busy, 0);
        check("mid_rst_valid", rsp_valid, 0);
        check("mid_rst_result", rsp_result, 0);
        check("mid_rst_error", rsp_error, 0);
        check("mid_rst_timeout", rsp_timeout, 0);
        check("mid_rst_in", eng_in, 0);
        req    = 4'b0011;
        req_in = 16'h0021;
        step();
        check("mid_hold_valid", rsp_valid, 0);
        check("mid_hold_ack", ack, 0);
        rst = 1'b0;
        op(0, 4'd1, 32'd1, 1'b1, 1'b0, 2, 1'b0, 4'b0001);
        check("post_rst_latency", last_wait, 1);
        op(1, 4'd2, 32'd2, 1'b1, 1'b0, 2, 1'b0, 4'b0010);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
